iomem_timer: RTL

Memory-mapped 32-bit timer/compare peripheral acting as a responder on the SoC's external `iomem_*` bus. It decodes its own 256-byte window, answers reads and byte-strobed writes with a registered one-cycle `iomem_ready`, and drives a level interrupt intended for one of the SoC's external IRQ inputs (`irq_5`). Several such responders may share the bus; this block is silent outside its window.

---
 rtl/iomem_timer_pkg.sv | 28 ++
 rtl/iomem_timer_if.sv | 19 +
 rtl/iomem_timer_prescaler.sv | 26 ++
 rtl/iomem_timer.sv | 107 ++++++++++
 4 files changed

// File: rtl/iomem_timer_pkg.sv
// Shared constants for the iomem_timer peripheral: register offsets, CTRL bit
// positions, default window base and a byte-strobe merge helper.
package iomem_timer_pkg;

   localparam logic [31:0] TMR_DEFAULT_BASE = 32'h0300_0000;

   localparam logic [7:0] TMR_CTRL     = 8'h00;
   localparam logic [7:0] TMR_PRESCALE = 8'h04;
   localparam logic [7:0] TMR_COUNT    = 8'h08;
   localparam logic [7:0] TMR_COMPARE  = 8'h0C;
   localparam logic [7:0] TMR_STATUS   = 8'h10;

   localparam int unsigned EN   = 0;
   localparam int unsigned IE   = 1;
   localparam int unsigned AUTO = 2;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/iomem_timer_if.sv
// iomem_* bus bundle: master drives requests, slave (responder) returns ready/rdata.
interface iomem_timer_if;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;

   modport master (
      output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      input  iomem_ready, iomem_rdata
   );

   modport slave (
      input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      output iomem_ready, iomem_rdata
   );
endinterface

// File: rtl/iomem_timer_prescaler.sv
// Enable-gated prescaler: counts 0..term_i and pulses tick_o on the terminal value.
module iomem_timer_prescaler #(
   parameter int unsigned PRE_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic [PRE_W-1:0] term_i,
   output logic             tick_o
);

   logic [PRE_W-1:0] cnt_q;

   assign tick_o = en_i & (cnt_q == term_i);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (!en_i || tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/iomem_timer.sv
// Memory-mapped 32-bit timer/compare responder on the iomem_* bus with a
// registered one-cycle ready and a registered level interrupt.
module iomem_timer
   import iomem_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = TMR_DEFAULT_BASE,
   parameter int unsigned PRE_W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   iomem_timer_if.slave bus,
   output logic         irq
);

   logic [2:0]       ctrl_q, ctrl_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [31:0]      count_q, count_d;
   logic [31:0]      cmp_q, cmp_d;
   logic             pend_q, pend_d;
   logic             irq_q, ready_q;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      pre_m;
   logic             in_win, accept, wr, tick, hit;
   logic [7:0]       off;
   logic             unused_addr;

   assign in_win      = (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign accept      = bus.iomem_valid & in_win & ~ready_q;
   assign wr          = accept & (|bus.iomem_wstrb);
   assign off         = {bus.iomem_addr[7:2], 2'b00};
   assign hit         = tick & (count_q == cmp_q);
   assign unused_addr = ^bus.iomem_addr[1:0];

   iomem_timer_prescaler #(.PRE_W(PRE_W)) u_pre (
      .clk    (clk),
      .reset  (reset),
      .en_i   (ctrl_q[EN]),
      .term_i (pre_q),
      .tick_o (tick)
   );

   always_comb begin
      rdata_d = '0;
      case (off)
         TMR_CTRL:     rdata_d[2:0]       = ctrl_q;
         TMR_PRESCALE: rdata_d[PRE_W-1:0] = pre_q;
         TMR_COUNT:    rdata_d            = count_q;
         TMR_COMPARE:  rdata_d            = cmp_q;
         TMR_STATUS:   rdata_d[0]         = pend_q;
         default:      rdata_d            = '0;
      endcase
   end

   // Timer update first, bus write overlays it; PEND set is applied last so it beats W1C.
   always_comb begin
      ctrl_d  = ctrl_q;
      pre_d   = pre_q;
      count_d = count_q;
      cmp_d   = cmp_q;
      pend_d  = pend_q;
      pre_m   = byte_merge(32'(pre_q), bus.iomem_wdata, bus.iomem_wstrb);
      if (hit) begin
         if (ctrl_q[AUTO]) count_d = '0;
         else              ctrl_d[EN] = 1'b0;
      end else if (tick) begin
         count_d = count_q + 32'd1;
      end
      if (wr) begin
         case (off)
            TMR_CTRL:     if (bus.iomem_wstrb[0]) ctrl_d = bus.iomem_wdata[2:0];
            TMR_PRESCALE: pre_d   = pre_m[PRE_W-1:0];
            TMR_COUNT:    count_d = byte_merge(count_d, bus.iomem_wdata, bus.iomem_wstrb);
            TMR_COMPARE:  cmp_d   = byte_merge(cmp_q, bus.iomem_wdata, bus.iomem_wstrb);
            TMR_STATUS:   if (bus.iomem_wstrb[0] && bus.iomem_wdata[0]) pend_d = 1'b0;
            default:      ;
         endcase
      end
      if (hit) pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q  <= '0;
         pre_q   <= '0;
         count_q <= '0;
         cmp_q   <= '0;
         pend_q  <= 1'b0;
         irq_q   <= 1'b0;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         pre_q   <= pre_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         pend_q  <= pend_d;
         irq_q   <= pend_q & ctrl_q[IE];
         ready_q <= accept;
         rdata_q <= accept ? rdata_d : '0;
      end
   end

   assign bus.iomem_ready = ready_q;
   assign bus.iomem_rdata = rdata_q;
   assign irq             = irq_q;

endmodule
